// File: rtl/fpu_multicycle_issuer.sv
// Initiator for the FPU multi-cycle unit protocol: holds enable and operands until the unit's
// ready pulse, then returns the result. Define FPU_ISSUE_TIMEOUT_EN to enable the WAIT watchdog.
module fpu_multicycle_issuer #(
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [$clog2(NUM_UNITS):0]      req_unit_i,
    input  logic [31:0]                     req_rs1_i,
    input  logic [31:0]                     req_rs2_i,
    input  logic [2:0]                      req_rm_i,
    input  logic [TAG_W-1:0]                req_tag_i,
    input  logic                            flush_i,
    output logic [NUM_UNITS-1:0]            unit_enable_o,
    output logic [31:0]                     unit_rs1_o,
    output logic [31:0]                     unit_rs2_o,
    output logic [2:0]                      unit_rm_o,
    input  logic [NUM_UNITS-1:0]            unit_ready_i,
    input  logic [32*NUM_UNITS-1:0]         unit_result_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [31:0]                     resp_data_o,
    output logic [TAG_W-1:0]                resp_tag_o,
    output logic                            resp_err_o,
    output logic                            busy_o
);
    localparam int unsigned UW = $clog2(NUM_UNITS) + 1;
    localparam logic [31:0] QNaN = 32'h7FC0_0000;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q;
    logic [UW-1:0]        sel_q;
    logic [NUM_UNITS-1:0] enable_q;
    logic [31:0]          rs1_q, rs2_q, data_q;
    logic [2:0]           rm_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 valid_q, err_q;

    logic                 accept, req_unit_ok, ready_sel, timeout;
    logic [31:0]          result_sel;
    logic [NUM_UNITS-1:0] req_onehot;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign req_ready_o = (state_q == StIdle) && !reset_i && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign req_unit_ok = req_unit_i < UW'(NUM_UNITS);

    // Only the selected unit's ready and result are looked at.
    always_comb begin
        ready_sel  = 1'b0;
        result_sel = '0;
        req_onehot = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            if (sel_q == UW'(k)) begin
                ready_sel  = unit_ready_i[k];
                result_sel = unit_result_i[32*k +: 32];
            end
            req_onehot[k] = (req_unit_i == UW'(k));
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    // Counts completed WAIT cycles; zero on the entry edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (state_q != StWait) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            enable_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rm_q     <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        rs1_q <= req_rs1_i;
                        rs2_q <= req_rs2_i;
                        rm_q  <= req_rm_i;
                        tag_q <= req_tag_i;
                        sel_q <= req_unit_i;
                        if (req_unit_ok) begin
                            enable_q <= req_onehot;
                            err_q    <= 1'b0;
                            state_q  <= StWait;
                        end else begin
                            data_q  <= QNaN;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StWait: begin
                    if (flush_i) begin
                        enable_q <= '0;
                        state_q  <= StIdle;
                    end else if (ready_sel) begin
                        // The unit may change its output next edge, so capture now.
                        data_q   <= result_sel;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        enable_q <= '0;
                        state_q  <= StResp;
                    end else if (timeout) begin
                        data_q   <= QNaN;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        enable_q <= '0;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    if (flush_i || resp_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    enable_q <= '0;
                    valid_q  <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign unit_enable_o = enable_q;
    assign unit_rs1_o    = rs1_q;
    assign unit_rs2_o    = rs2_q;
    assign unit_rm_o     = rm_q;
    assign resp_valid_o  = valid_q;
    assign resp_data_o   = data_q;
    assign resp_tag_o    = tag_q;
    assign resp_err_o    = err_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_multicycle_issuer.sv
// Bench for fpu_multicycle_issuer: stub units with programmable latency plus a response model.
// Build with FPU_ISSUE_TIMEOUT_EN defined to exercise the watchdog.
module tb_fpu_multicycle_issuer;
    localparam int NU = 2;
    localparam int TW = 5;
    localparam int TO = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            req_valid_i = 1'b0, req_ready_o;
    logic [1:0]      req_unit_i = '0;
    logic [31:0]     req_rs1_i = '0, req_rs2_i = '0;
    logic [2:0]      req_rm_i = '0;
    logic [TW-1:0]   req_tag_i = '0;
    logic            flush_i = 1'b0;
    logic [NU-1:0]   unit_enable_o;
    logic [31:0]     unit_rs1_o, unit_rs2_o;
    logic [2:0]      unit_rm_o;
    logic [NU-1:0]   unit_ready_i = '0;
    logic [32*NU-1:0] unit_result_i;
    logic            resp_valid_o, resp_ready_i = 1'b0;
    logic [31:0]     resp_data_o;
    logic [TW-1:0]   resp_tag_o;
    logic            resp_err_o, busy_o;

    int vectors = 0;
    int miscompares = 0;
    int lat [NU] = '{default: 3};
    int cnt [NU] = '{default: 0};
    logic [31:0] res [NU] = '{default: 32'd0};
    bit noise = 0;

    always #5 clk_i = ~clk_i;

    fpu_multicycle_issuer #(.NUM_UNITS(NU), .TAG_W(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_unit_i(req_unit_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rm_i(req_rm_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
        .unit_enable_o(unit_enable_o), .unit_rs1_o(unit_rs1_o), .unit_rs2_o(unit_rs2_o),
        .unit_rm_o(unit_rm_o), .unit_ready_i(unit_ready_i), .unit_result_i(unit_result_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
    );

    // What each stub unit computes (unit 0 mimics a few FSQRT results).
    function automatic logic [31:0] unit_fn(input int k, input logic [31:0] a,
                                            input logic [31:0] b, input logic [2:0] rm);
        if (k == 0) begin
            if (a == 32'h4080_0000) return 32'h4000_0000;
            if (a[31]) return 32'hFFC0_0000;
            return {1'b0, a[30:0]} ^ {29'd0, rm};
        end
        return (a + b) ^ {29'd0, rm};
    endfunction

    function automatic logic [NU-1:0] onehot(input int u);
        logic [NU-1:0] r = '0;
        if (u < NU) r[u] = 1'b1;
        return r;
    endfunction

    // Stub units: count while enabled, pulse ready after lat cycles, garbage result otherwise.
    always @(negedge clk_i) begin
        for (int k = 0; k < NU; k++) begin
            if (!unit_enable_o[k]) begin
                cnt[k] = 0;
                unit_ready_i[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                res[k] = $urandom;
            end else if (cnt[k] == lat[k] - 1) begin
                cnt[k] = 0;
                unit_ready_i[k] = 1'b1;
                res[k] = unit_fn(k, unit_rs1_o, unit_rs2_o, unit_rm_o);
            end else begin
                cnt[k] = cnt[k] + 1;
                unit_ready_i[k] = 1'b0;
                res[k] = $urandom;
            end
        end
    end

    always_comb begin
        unit_result_i = '0;
        for (int k = 0; k < NU; k++) unit_result_i[32*k +: 32] = res[k];
    end

    // Issue one request; returns at the first negedge after acceptance.
    task automatic send(input logic [1:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [TW-1:0] tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (req_ready_o) ok = 1;
            else @(negedge clk_i);
        end
        if (ok) begin
            req_unit_i = u; req_rs1_i = a; req_rs2_i = b; req_rm_i = rm; req_tag_i = tag;
            req_valid_i = 1'b1;
            @(negedge clk_i);
            req_valid_i = 1'b0;
        end
    endtask

    // Count negedges until resp_valid_o; n = -1 if the bound expires.
    task automatic wait_valid(input int maxc, input logic [NU-1:0] en, input logic [31:0] a,
                              input logic [31:0] b, output int n, output bit held);
        n = -1;
        held = 1;
        for (int i = 0; i <= maxc; i++) begin
            if (resp_valid_o) begin
                n = i;
                break;
            end
            if (unit_enable_o !== en || unit_rs1_o !== a || unit_rs2_o !== b) held = 0;
            @(negedge clk_i);
        end
    endtask

    task automatic ack();
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        req_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({req_ready_o, busy_o, unit_enable_o, resp_valid_o, resp_err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0",
                     {req_ready_o, busy_o, unit_enable_o, resp_valid_o, resp_err_o});
        end
        vectors++;
        if ({unit_rs1_o, unit_rs2_o, unit_rm_o, resp_data_o, resp_tag_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0",
                     {unit_rs1_o, unit_rs2_o, unit_rm_o, resp_data_o, resp_tag_o});
        end
        req_valid_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b want 1/0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_sqrt();
        bit ok, held;
        int n;
        lat[0] = 4;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd5, ok);
        vectors++;
        if (!ok || unit_enable_o !== 2'b01 || unit_rs1_o !== 32'h4080_0000) begin
            miscompares++;
            $display("FAIL sqrt_enable: ok=%0d en=%b rs1=%h want 01/40800000", ok, unit_enable_o,
                     unit_rs1_o);
        end
        wait_valid(20, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== 4 || !held) begin
            miscompares++;
            $display("FAIL sqrt_latency: cycles=%0d held=%0d want 4/1", n, held);
        end
        vectors++;
        if ({resp_data_o, resp_tag_o, resp_err_o, unit_enable_o} !== {32'h4000_0000, 5'd5, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL sqrt_resp: data=%h tag=%0d err=%b en=%b want 40000000/5/0/00",
                     resp_data_o, resp_tag_o, resp_err_o, unit_enable_o);
        end
        ack();
        lat[0] = 3;
        send(2'd0, 32'hBF80_0000, 32'd0, 3'd0, 5'd17, ok);
        wait_valid(20, 2'b01, 32'hBF80_0000, 32'd0, n, held);
        vectors++;
        if (n !== 3 || {resp_data_o, resp_tag_o, resp_err_o} !== {32'hFFC0_0000, 5'd17, 1'b0}) begin
            miscompares++;
            $display("FAIL sqrt_neg: n=%0d data=%h tag=%0d err=%b want 3/ffc00000/17/0", n,
                     resp_data_o, resp_tag_o, resp_err_o);
        end
        @(negedge clk_i);
        vectors++;
        if (unit_enable_o !== 2'b00 || resp_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_low_after_ready: en=%b valid=%b want 00/1", unit_enable_o,
                     resp_valid_o);
        end
        ack();
        vectors++;
        if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL resp_drop: valid=%b busy=%b want 0/0", resp_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, held, stable;
        int n, low;
        logic [31:0] exp_a;
        lat[1] = 2;
        lat[0] = 2;
        exp_a = unit_fn(1, 32'h3F80_0000, 32'h4000_0000, 3'd1);
        send(2'd1, 32'h3F80_0000, 32'h4000_0000, 3'd1, 5'd9, ok);
        wait_valid(20, 2'b10, 32'h3F80_0000, 32'h4000_0000, n, held);
        vectors++;
        if (n !== 2 || !held || resp_data_o !== exp_a || resp_tag_o !== 5'd9) begin
            miscompares++;
            $display("FAIL b2b_first: n=%0d held=%0d data=%h tag=%0d want 2/1/%h/9", n, held,
                     resp_data_o, resp_tag_o, exp_a);
        end
        req_unit_i = 2'd0; req_rs1_i = 32'h4080_0000; req_rs2_i = 32'd0; req_rm_i = 3'd0;
        req_tag_i = 5'd3; req_valid_i = 1'b1;
        stable = 1;
        repeat (5) begin
            @(negedge clk_i);
            if (!resp_valid_o || resp_data_o !== exp_a || req_ready_o || unit_enable_o !== 2'b00)
                stable = 0;
        end
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL b2b_hold: stable=%0d want 1", stable);
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        vectors++;
        if (resp_valid_o !== 1'b0 || unit_enable_o !== 2'b00 || req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: valid=%b en=%b ready=%b want 0/00/1", resp_valid_o,
                     unit_enable_o, req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        vectors++;
        if (unit_enable_o !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_accept: en=%b want 01", unit_enable_o);
        end
        wait_valid(20, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== 2 || resp_data_o !== 32'h4000_0000 || resp_tag_o !== 5'd3) begin
            miscompares++;
            $display("FAIL b2b_second: n=%0d data=%h tag=%0d want 2/40000000/3", n, resp_data_o,
                     resp_tag_o);
        end
        // Immediate ack with the next request already waiting: minimum enable gap.
        req_unit_i = 2'd1; req_rs1_i = 32'd7; req_rs2_i = 32'd9; req_tag_i = 5'd4;
        req_valid_i = 1'b1;
        resp_ready_i = 1'b1;
        low = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            resp_ready_i = 1'b0;
            if (unit_enable_o == 2'b00) low++;
            else break;
        end
        req_valid_i = 1'b0;
        vectors++;
        if (low !== 2 || unit_enable_o !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_min_gap: low=%0d en=%b want 2/10", low, unit_enable_o);
        end
        wait_valid(20, 2'b10, 32'd7, 32'd9, n, held);
        vectors++;
        if (resp_data_o !== unit_fn(1, 32'd7, 32'd9, 3'd0) || resp_tag_o !== 5'd4) begin
            miscompares++;
            $display("FAIL b2b_third: data=%h tag=%0d want %h/4", resp_data_o, resp_tag_o,
                     unit_fn(1, 32'd7, 32'd9, 3'd0));
        end
        ack();
    endtask

    task automatic test_flush();
        bit ok, held, quiet;
        int n;
        lat[0] = 40;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd7, ok);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        vectors++;
        if ({unit_enable_o, resp_valid_o, busy_o} !== '0) begin
            miscompares++;
            $display("FAIL flush_wait: en=%b valid=%b busy=%b want 0", unit_enable_o,
                     resp_valid_o, busy_o);
        end
        quiet = 1;
        repeat (5) begin
            @(negedge clk_i);
            if (resp_valid_o) quiet = 0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL flush_no_resp: quiet=%0d want 1", quiet);
        end
        req_unit_i = 2'd0; req_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        vectors++;
        if (req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_gates_ready: ready=%b want 0", req_ready_o);
        end
        @(negedge clk_i);
        flush_i = 1'b0; req_valid_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || unit_enable_o !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_idle_noaccept: busy=%b en=%b want 0/00", busy_o, unit_enable_o);
        end
        lat[0] = 2;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd8, ok);
        wait_valid(20, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== 2 || resp_data_o !== 32'h4000_0000 || resp_tag_o !== 5'd8) begin
            miscompares++;
            $display("FAIL flush_followup: n=%0d data=%h tag=%0d want 2/40000000/8", n,
                     resp_data_o, resp_tag_o);
        end
        ack();
        lat[0] = 3;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd1, ok);
        repeat (2) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        vectors++;
        if ({resp_valid_o, busy_o, unit_enable_o} !== '0) begin
            miscompares++;
            $display("FAIL flush_beats_ready: valid=%b busy=%b en=%b want 0", resp_valid_o,
                     busy_o, unit_enable_o);
        end
        send(2'd2, 32'd1, 32'd2, 3'd0, 5'd2, ok);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        vectors++;
        if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_resp: valid=%b busy=%b want 0/0", resp_valid_o, busy_o);
        end
    endtask

    task automatic test_invalid_unit();
        bit ok;
        send(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 5'd21, ok);
        vectors++;
        if ({unit_enable_o, resp_valid_o, resp_data_o, resp_err_o, resp_tag_o}
            !== {2'b00, 1'b1, QNAN, 1'b1, 5'd21}) begin
            miscompares++;
            $display("FAIL invalid_unit: en=%b valid=%b data=%h err=%b tag=%0d want 00/1/%h/1/21",
                     unit_enable_o, resp_valid_o, resp_data_o, resp_err_o, resp_tag_o, QNAN);
        end
        ack();
    endtask

    task automatic test_random();
        bit ok, held, stable;
        int n, u, exp_n, d;
        logic [31:0] a, b, exp_d;
        logic [2:0] rm;
        logic [TW-1:0] tag;
        logic exp_e;
        noise = 1;
        for (int it = 0; it < 25; it++) begin
            u = $urandom_range(0, 3);
            a = $urandom; b = $urandom; rm = 3'($urandom_range(0, 7)); tag = TW'($urandom);
            if (u < NU) begin
                lat[u] = $urandom_range(1, 6);
                exp_n = lat[u]; exp_d = unit_fn(u, a, b, rm); exp_e = 1'b0;
            end else begin
                exp_n = 0; exp_d = QNAN; exp_e = 1'b1;
            end
            send(2'(u), a, b, rm, tag, ok);
            wait_valid(20, onehot(u), a, b, n, held);
            vectors++;
            if (n !== exp_n || !held) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: unit=%0d n=%0d held=%0d want %0d/1", it, u, n,
                         held, exp_n);
            end
            vectors++;
            if ({resp_data_o, resp_tag_o, resp_err_o} !== {exp_d, tag, exp_e}) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: unit=%0d data=%h tag=%0d err=%b want %h/%0d/%b",
                         it, u, resp_data_o, resp_tag_o, resp_err_o, exp_d, tag, exp_e);
            end
            d = $urandom_range(0, 3);
            stable = 1;
            repeat (d) begin
                @(negedge clk_i);
                if (!resp_valid_o || resp_data_o !== exp_d) stable = 0;
            end
            vectors++;
            if (!stable) begin
                miscompares++;
                $display("FAIL rand_hold[%0d]: stable=%0d want 1", it, stable);
            end
            ack();
        end
        noise = 0;
    endtask

    task automatic test_async_reset();
        bit ok, held;
        int n;
        lat[1] = 50;
        send(2'd1, 32'd3, 32'd4, 3'd0, 5'd6, ok);
        repeat (3) @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        vectors++;
        if ({unit_enable_o, busy_o, req_ready_o, resp_valid_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: en=%b busy=%b ready=%b valid=%b want 0", unit_enable_o,
                     busy_o, req_ready_o, resp_valid_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        lat[1] = 2;
        send(2'd1, 32'd3, 32'd4, 3'd2, 5'd6, ok);
        wait_valid(20, 2'b10, 32'd3, 32'd4, n, held);
        vectors++;
        if (n !== 2 || resp_data_o !== unit_fn(1, 32'd3, 32'd4, 3'd2)) begin
            miscompares++;
            $display("FAIL after_reset: n=%0d data=%h want 2/%h", n, resp_data_o,
                     unit_fn(1, 32'd3, 32'd4, 3'd2));
        end
        ack();
    endtask

    task automatic test_timeout();
        bit ok, held;
        int n;
`ifdef FPU_ISSUE_TIMEOUT_EN
        lat[0] = 1000;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd11, ok);
        wait_valid(40, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== TO || {resp_data_o, resp_err_o, resp_tag_o, unit_enable_o}
            !== {QNAN, 1'b1, 5'd11, 2'b00}) begin
            miscompares++;
            $display("FAIL timeout: n=%0d data=%h err=%b tag=%0d en=%b want %0d/%h/1/11/00", n,
                     resp_data_o, resp_err_o, resp_tag_o, unit_enable_o, TO, QNAN);
        end
        ack();
        lat[0] = TO;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd12, ok);
        wait_valid(40, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== TO || resp_data_o !== 32'h4000_0000 || resp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_ready_wins: n=%0d data=%h err=%b want %0d/40000000/0", n,
                     resp_data_o, resp_err_o, TO);
        end
        ack();
`else
        lat[0] = 3 * TO;
        send(2'd0, 32'h4080_0000, 32'd0, 3'd0, 5'd11, ok);
        wait_valid(80, 2'b01, 32'h4080_0000, 32'd0, n, held);
        vectors++;
        if (n !== 3 * TO || !held || resp_data_o !== 32'h4000_0000 || resp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL long_wait: n=%0d held=%0d data=%h err=%b want %0d/1/40000000/0", n,
                     held, resp_data_o, resp_err_o, 3 * TO);
        end
        ack();
`endif
    endtask

    initial begin
        test_reset();
        test_sqrt();
        test_back_to_back();
        test_flush();
        test_invalid_unit();
        test_random();
        test_async_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_multicycle_issuer.md
Name: fpu_multicycle_issuer

Overview:
- Initiator side of the FPU multi-cycle unit protocol (enable-held / ready-pulse), used by FSQRT, FDIV and later iterative units.
- Accepts one FP operation from the execute stage over a valid/ready handshake.
- Drives the selected unit's enable with stable operands until that unit's ready pulse, captures the result, and returns it with the destination tag to writeback.
- Stalls issue while an operation is in flight.

Parameters:
- NUM_UNITS, 2, number of attached multi-cycle units (index 0 = FSQRT, 1 = FDIV).
- TAG_W, 5, width of the destination-register tag.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with FPU_ISSUE_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  issuer can accept a request.
- req_unit_i  in  $clog2(NUM_UNITS)+1  target unit index.
- req_rs1_i  in  32  operand 1.
- req_rs2_i  in  32  operand 2.
- req_rm_i  in  3  resolved rounding mode.
- req_tag_i  in  TAG_W  destination tag.
- flush_i  in  1  abort the in-flight operation, no response.
- unit_enable_o  out  NUM_UNITS  one-hot enable to the units.
- unit_rs1_o  out  32  held operand 1 (shared by all units).
- unit_rs2_o  out  32  held operand 2.
- unit_rm_o  out  3  held rounding mode.
- unit_ready_i  in  NUM_UNITS  per-unit completion pulse.
- unit_result_i  in  32*NUM_UNITS  per-unit result; unit k occupies bits [32k+31:32k].
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  writeback accepts the response.
- resp_data_o  out  32  result.
- resp_tag_o  out  TAG_W  destination tag.
- resp_err_o  out  1  result is a substituted NaN (invalid unit or timeout).
- busy_o  out  1  operation in flight (IDLE excluded).

Behaviour:
- Reset (asynchronous, while reset_i is high):
  - state = IDLE.
  - unit_enable_o = 0.
  - resp_valid_o = 0, resp_err_o = 0.
  - resp_data_o, resp_tag_o, unit_rs1_o, unit_rs2_o, unit_rm_o = 0.
  - req_ready_o = 0 (gated by reset_i), busy_o = 0.
- States: IDLE, WAIT, RESP. req_ready_o = (state == IDLE) && !reset_i.
- IDLE:
  - On req_valid_i && req_ready_o: latch rs1, rs2, rm, tag and unit index.
  - If the index is < NUM_UNITS: go to WAIT; that unit's enable bit goes high from the next cycle. Latency from acceptance to enable is 1 cycle.
  - If the index is >= NUM_UNITS: go directly to RESP with data 0x7FC00000 and resp_err_o = 1. No enable is raised.
- WAIT:
  - unit_enable_o[sel] is held high and the unit_* operand outputs are held constant every cycle.
  - Only unit_ready_i[sel] is sampled; ready bits of other units are ignored.
  - On the rising edge where unit_ready_i[sel] = 1: capture unit_result_i[sel] into resp_data_o on that same edge. The unit may overwrite its output on the next edge, so capture is never delayed.
  - On that edge also clear unit_enable_o and go to RESP with resp_valid_o = 1.
  - If the unit re-arms for one cycle because enable was still high at that edge, its result is discarded. Enable stays low for at least 1 cycle before any new issue, which returns the unit's counter to 0.
- RESP:
  - resp_valid_o and data/tag/err are held until resp_ready_i = 1.
  - On resp_ready_i go to IDLE and drop resp_valid_o.
  - The earliest next enable is 2 cycles after the response handshake (accept in IDLE, then a registered enable).
- flush_i:
  - In WAIT: clear enable next edge, go to IDLE, no response.
  - In RESP: drop the response, go to IDLE.
  - In IDLE: a simultaneous request is not accepted (flush has priority; req_ready_o is gated by flush_i).
- Ready and flush on the same edge in WAIT: flush wins and the result is discarded.
- Asynchronous reset mid-operation: enable drops immediately (asynchronously); the unit self-clears because its enable is low.

Optional Feature:
- Macro FPU_ISSUE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without a ready pulse: clear enable, go to RESP with data 0x7FC00000 and resp_err_o = 1.
  - A ready pulse on the same edge as the timeout wins.
- Undefined: no counter; WAIT persists until ready or flush. resp_err_o is only set by invalid-unit requests.

Test Plan:
- Unit 0 (FSQRT), rs1 = 0x40800000 (4.0), rm = 0 → enable high 1 cycle after accept, held until ready; response data 0x40000000, correct tag, err = 0.
- Unit 0, rs1 = 0xBF800000 (-1.0) → data 0xFFC00000 from the unit's special path, err = 0. Check that enable drops on the ready edge and stays low ≥1 cycle.
- Back-to-back requests with resp_ready_i held low 5 cycles → resp_valid_o and data stable for 5 cycles; second request not accepted until the handshake completes; enable gap ≥ 2 cycles.
- flush_i pulsed 10 cycles into a sqrt → enable low the next cycle, no resp_valid_o; a following request completes normally with the correct result.
- req_unit_i = 3 → no enable raised; response next cycle with 0x7FC00000, err = 1.
- With FPU_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and a stub unit that never readies → response 0x7FC00000, err = 1 exactly 8 cycles after enable rose.
